// File: rtl/sha1_stream_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha1_stream_if : word-stream input and digest output bundle for sha1_stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface sha1_stream_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         in_ready;
  logic [159:0] digest;
  logic         digest_valid;
  logic         busy;

  modport master (
    output in_data, in_valid, in_last, in_nbytes,
    input  in_ready, digest, digest_valid, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, in_nbytes,
    output in_ready, digest, digest_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/sha1_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sha1_stream : streaming SHA-1, one 80-round compression per HASH cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module sha1_stream (
  input  wire logic     clk,
  input  wire logic     rst,
  sha1_stream_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LOAD = 3'd0,
    S_PAD  = 3'd1,
    S_LEN  = 3'd2,
    S_HASH = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [159:0] c_h_init =
    160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  state_t              r_state;
  logic [4:0]          r_wcnt;
  logic [63:0]         r_len;
  logic                r_pad_done;
  logic                r_len_done;
  logic                r_msg_end;
  logic [15:0][31:0]   r_block;
  logic [159:0]        r_chain;
  logic [159:0]        r_digest;
  logic                r_digest_valid;

  logic [2:0]          w_nbytes;
  logic [31:0]         w_last_word;
  logic [31:0]         w_load_word;
  logic                w_load_pad;
  logic [63:0]         w_len_inc;
  logic [4:0]          w_wcnt_inc;
  logic [159:0]        w_hash;

  function automatic logic [159:0] sha1_compress(input logic [159:0] h,
                                                 input logic [511:0] blk);
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, e, f, k, wt, x, tmp;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int t = 0; t < 80; t++) begin
      // 16-entry circular schedule: t-3, t-8, t-14, t-16 map to t+13, t+8, t+2, t
      if (t < 16) begin
        wt = w[4'(t)];
      end else begin
        x  = w[4'(t+13)] ^ w[4'(t+8)] ^ w[4'(t+2)] ^ w[4'(t)];
        wt = {x[30:0], x[31]};
        w[4'(t)] = wt;
      end
      if (t < 20) begin
        f = (b & c) | (~b & d);          k = 32'h5A827999;
      end else if (t < 40) begin
        f = b ^ c ^ d;                   k = 32'h6ED9EBA1;
      end else if (t < 60) begin
        f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC;
      end else begin
        f = b ^ c ^ d;                   k = 32'hCA62C1D6;
      end
      tmp = {a[26:0], a[31:27]} + f + e + k + wt;
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic state_t next_after_write(input logic [4:0] wnext,
                                              input logic ended,
                                              input logic pad);
    if (wnext == 5'd16)                       return S_HASH;
    else if (ended && pad && wnext == 5'd14)  return S_LEN;
    else if (ended)                           return S_PAD;
    else                                      return S_LOAD;
  endfunction

  always_comb begin
    w_nbytes = (bus.in_nbytes == 3'd0 || bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
    case (w_nbytes)
      3'd1:    w_last_word = {bus.in_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_last_word = {bus.in_data[31:16], 8'h80, 8'h00};
      3'd3:    w_last_word = {bus.in_data[31:8], 8'h80};
      default: w_last_word = bus.in_data;
    endcase
    w_load_word = bus.in_last ? w_last_word : bus.in_data;
    w_load_pad  = bus.in_last && (w_nbytes != 3'd4);
    w_len_inc   = bus.in_last ? {58'd0, w_nbytes, 3'b000} : 64'd32;
    w_wcnt_inc  = r_wcnt + 5'd1;
    w_hash      = sha1_compress(r_chain, r_block);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_LOAD;
      r_wcnt         <= 5'd0;
      r_len          <= 64'd0;
      r_pad_done     <= 1'b0;
      r_len_done     <= 1'b0;
      r_msg_end      <= 1'b0;
      r_block        <= '0;
      r_chain        <= c_h_init;
      r_digest       <= 160'd0;
      r_digest_valid <= 1'b0;
    end else begin
      r_digest_valid <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (bus.in_valid) begin
            r_block[4'd15 - r_wcnt[3:0]] <= w_load_word;
            r_wcnt <= w_wcnt_inc;
            r_len  <= r_len + w_len_inc;
            if (w_load_pad)  r_pad_done <= 1'b1;
            if (bus.in_last) r_msg_end  <= 1'b1;
            r_state <= next_after_write(w_wcnt_inc, bus.in_last | r_msg_end,
                                        w_load_pad | r_pad_done);
          end
        end
        S_PAD: begin
          r_block[4'd15 - r_wcnt[3:0]] <= r_pad_done ? 32'h0000_0000 : 32'h8000_0000;
          r_pad_done <= 1'b1;
          r_wcnt     <= w_wcnt_inc;
          r_state    <= next_after_write(w_wcnt_inc, 1'b1, 1'b1);
        end
        S_LEN: begin
          r_block[1] <= r_len[63:32];
          r_block[0] <= r_len[31:0];
          r_len_done <= 1'b1;
          r_state    <= S_HASH;
        end
        S_HASH: begin
          r_chain <= w_hash;
          r_wcnt  <= 5'd0;
          if (r_len_done)     r_state <= S_DONE;
          else if (r_msg_end) r_state <= S_PAD;
          else                r_state <= S_LOAD;
        end
        S_DONE: begin
          r_digest       <= r_chain;
          r_digest_valid <= 1'b1;
          r_chain        <= c_h_init;
          r_len          <= 64'd0;
          r_pad_done     <= 1'b0;
          r_len_done     <= 1'b0;
          r_msg_end      <= 1'b0;
          r_state        <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign bus.in_ready     = (r_state == S_LOAD);
  assign bus.busy         = !((r_state == S_LOAD) && (r_wcnt == 5'd0));
  assign bus.digest       = r_digest;
  assign bus.digest_valid = r_digest_valid;

endmodule
`default_nettype wire

// File: tb/tb_sha1_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sha1_stream : scoreboard bench for sha1_stream against a byte-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_sha1_stream;

  typedef byte unsigned bq_t[$];

  localparam logic [159:0] c_abc  = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] c_two  = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [159:0] sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha1_stream_if bif ();
  sha1_stream dut (.clk(clk), .rst(rst), .bus(bif));

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic logic [159:0] sha1_model(input bq_t m);
    bq_t p;
    logic [63:0] bits;
    logic [31:0] h0, h1, h2, h3, h4, a, b, c, d, e, f, k, x, tmp;
    logic [31:0] w [80];
    p = m;
    bits = 64'(m.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    h0 = 32'h67452301; h1 = 32'hEFCDAB89; h2 = 32'h98BADCFE; h3 = 32'h10325476; h4 = 32'hC3D2E1F0;
    for (int off = 0; off < p.size(); off += 64) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[off+4*t], p[off+4*t+1], p[off+4*t+2], p[off+4*t+3]};
      for (int t = 16; t < 80; t++) begin
        x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
        w[t] = (x << 1) | (x >> 31);
      end
      a = h0; b = h1; c = h2; d = h3; e = h4;
      for (int t = 0; t < 80; t++) begin
        case (t / 20)
          0:       begin f = (b & c) | ((~b) & d);        k = 32'h5A827999; end
          1:       begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
          2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
          default: begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
        endcase
        tmp = ((a << 5) | (a >> 27)) + f + e + k + w[t];
        e = d; d = c; c = (b << 30) | (b >> 2); b = a; a = tmp;
      end
      h0 += a; h1 += b; h2 += c; h3 += d; h4 += e;
    end
    return {h0, h1, h2, h3, h4};
  endfunction

  // Unused bytes of the final word carry random junk so the byte masking is exercised.
  task automatic drive_msg(input bq_t m, input bit zero_nb, input bit hold, output int acc_cyc);
    int nw, nb, n;
    logic [31:0] dw;
    nw = (m.size() + 3) / 4;
    acc_cyc = 0;
    for (int wi = 0; wi < nw; wi++) begin
      nb = (wi == nw - 1) ? m.size() - 4 * wi : 4;
      for (int bi = 0; bi < 4; bi++) dw[31-8*bi -: 8] = (bi < nb) ? m[4*wi+bi] : 8'($urandom);
      @(negedge clk);
      bif.in_valid  = 1'b1;
      bif.in_data   = dw;
      bif.in_last   = (wi == nw - 1);
      bif.in_nbytes = (wi != nw - 1) ? 3'($urandom) : ((nb == 4 && zero_nb) ? 3'd0 : 3'(nb));
      n = 0;
      while (!bif.in_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout word %0d: in_ready=%b required 1", wi, bif.in_ready);
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
    end
    if (hold) begin
      bif.in_data = $urandom; bif.in_last = 1'($urandom); bif.in_nbytes = 3'($urandom);
    end else begin
      bif.in_valid = 1'b0;
    end
  endtask

  task automatic wait_digest(output bit found, output logic [159:0] dg, output int det_cyc,
                             output int ready_bad, output logic dv_after);
    found = 1'b0; dg = '0; det_cyc = 0; ready_bad = 0; dv_after = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(negedge clk);
      if (bif.digest_valid === 1'b1) begin
        found = 1'b1; dg = bif.digest; det_cyc = cyc;
        bif.in_valid = 1'b0;
        @(negedge clk);
        dv_after = bif.digest_valid;
      end else if (bif.in_ready !== 1'b0) begin
        ready_bad++;
      end
    end
    bif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bif.in_valid = 1'b0; bif.in_data = '0; bif.in_last = 1'b0; bif.in_nbytes = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bif.in_ready); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bif.busy); end
    checks++; if (bif.digest !== 160'd0) begin errors++; $display("FAIL reset_digest got %h want 0", bif.digest); end
    checks++; if (bif.digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest_valid got %b want 0", bif.digest_valid); end
  endtask

  task automatic test_abc();
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva;
    sb.push_back(c_abc);
    drive_msg(str2q("abc"), 1'b0, 1'b0, acc);
    wait_digest(found, dg, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg !== exp) begin errors++; $display("FAIL abc_digest got %h want %h", dg, exp); end
    checks++; if (det - acc != 16) begin errors++; $display("FAIL abc_latency got %0d want 16", det - acc); end
    checks++; if (dva !== 1'b0) begin errors++; $display("FAIL abc_pulse_width got %b want 0", dva); end
    checks++; if (rb != 0) begin errors++; $display("FAIL abc_in_ready_busy got %0d want 0", rb); end
    repeat (6) @(negedge clk);
    checks++; if (bif.digest !== exp) begin errors++; $display("FAIL abc_digest_hold got %h want %h", bif.digest, exp); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL abc_idle_busy got %b want 0", bif.busy); end
  endtask

  task automatic test_two_block();
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva;
    sb.push_back(c_two);
    drive_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, 1'b0, acc);
    wait_digest(found, dg, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg !== exp) begin errors++; $display("FAIL two_block_digest got %h want %h", dg, exp); end
    checks++; if (rb != 0) begin errors++; $display("FAIL two_block_in_ready got %0d want 0", rb); end
  endtask

  task automatic test_full_block();
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva; bq_t m;
    for (int i = 0; i < 64; i++) m.push_back(8'(i * 37 + 11));
    sb.push_back(sha1_model(m));
    drive_msg(m, 1'b0, 1'b0, acc);
    wait_digest(found, dg, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg !== exp) begin errors++; $display("FAIL full_block_digest got %h want %h", dg, exp); end
    checks++; if (rb != 0) begin errors++; $display("FAIL full_block_in_ready got %0d want 0", rb); end
  endtask

  task automatic test_latency_k12();
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva; bq_t m;
    for (int i = 0; i < 49; i++) m.push_back(8'($urandom));
    sb.push_back(sha1_model(m));
    drive_msg(m, 1'b0, 1'b0, acc);
    wait_digest(found, dg, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg !== exp) begin errors++; $display("FAIL k12_digest got %h want %h", dg, exp); end
    checks++; if (det - acc != 4) begin errors++; $display("FAIL k12_latency got %0d want 4", det - acc); end
  endtask

  task automatic test_lengths();
    int lens [9] = '{1, 2, 3, 4, 5, 55, 57, 63, 65};
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva; bq_t m;
    foreach (lens[li]) begin
      m.delete();
      for (int i = 0; i < lens[li]; i++) m.push_back(8'($urandom));
      sb.push_back(sha1_model(m));
      // 4-byte message uses in_nbytes=0, which must be read as a full word
      drive_msg(m, lens[li] == 4, 1'b0, acc);
      wait_digest(found, dg, det, rb, dva);
      exp = sb.pop_front();
      checks++; if (!found || dg !== exp) begin errors++; $display("FAIL len%0d_digest got %h want %h", lens[li], dg, exp); end
    end
  endtask

  task automatic test_back_to_back();
    int acc, det, rb; bit found; logic [159:0] dg1, dg2, exp; logic dva;
    sb.push_back(c_abc);
    sb.push_back(c_abc);
    drive_msg(str2q("abc"), 1'b0, 1'b1, acc);
    wait_digest(found, dg1, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg1 !== exp) begin errors++; $display("FAIL b2b_first_digest got %h want %h", dg1, exp); end
    checks++; if (rb != 0) begin errors++; $display("FAIL b2b_backpressure got %0d ready cycles want 0", rb); end
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_consume busy got %b want 0", bif.busy); end
    drive_msg(str2q("abc"), 1'b0, 1'b0, acc);
    wait_digest(found, dg2, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg2 !== exp) begin errors++; $display("FAIL b2b_second_digest got %h want %h", dg2, exp); end
  endtask

  task automatic test_reset_mid();
    int acc, det, rb; bit found; logic [159:0] dg, exp; logic dva;
    for (int wi = 0; wi < 5; wi++) begin
      @(negedge clk);
      bif.in_valid = 1'b1; bif.in_data = $urandom; bif.in_last = 1'b0; bif.in_nbytes = 3'd4;
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", bif.busy); end
    sb.push_back(c_abc);
    drive_msg(str2q("abc"), 1'b0, 1'b0, acc);
    wait_digest(found, dg, det, rb, dva);
    exp = sb.pop_front();
    checks++; if (!found || dg !== exp) begin errors++; $display("FAIL mid_reset_digest got %h want %h", dg, exp); end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_full_block();
    test_latency_k12();
    test_lengths();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha1_stream.md
SHA1_STREAM -- requirements
Module: sha1_stream

Interface
REQ-001 SHALL have no parameters; widths are fixed by SHA-1.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_data  in  32  message word, big-endian (first byte in [31:24]).
REQ-005 in_valid  in  1  in_data, in_last and in_nbytes valid.
REQ-006 in_last  in  1  current word is the final word of the message.
REQ-007 in_nbytes  in  3  valid bytes in the final word, 1..4; ignored unless in_last=1.
REQ-008 in_ready  out  1  word accepted on a cycle with in_valid=1 and in_ready=1.
REQ-009 digest  out  160  H0 in [159:128] through H4 in [31:0].
REQ-010 digest_valid  out  1  one-cycle pulse when digest is updated.
REQ-011 busy  out  1  high in every state except LOAD with word count 0.

Function
REQ-012 SHALL feed one instance of the combinational SHA-1 compression stage with:
- a 512-bit block register, word i at bits [511-32i -: 32];
- a 160-bit chaining register, A in [159:128] and E in [31:0].
REQ-013 SHALL implement FSM states LOAD, PAD, LEN, HASH and DONE; reset state is LOAD.
REQ-014 SHALL keep a word counter wcnt (0..16), a 64-bit bit-length counter len, and flags pad_done and len_done.
REQ-015 LOAD SHALL assert in_ready=1; all other states SHALL drive in_ready=0, and input there is ignored.
REQ-016 Each accepted word SHALL be written to block word wcnt, wcnt incremented, and len increased by 32, or by 8*in_nbytes for the last word.
REQ-017 In a last word with in_nbytes<4:
- byte position in_nbytes SHALL be forced to 0x80 and later bytes to 0x00;
- pad_done SHALL be set.
With in_nbytes=4, pad_done SHALL stay clear.
REQ-018 After any write in LOAD or PAD, next state SHALL be:
- HASH if wcnt becomes 16;
- else LEN if the message has ended, pad_done=1 and wcnt becomes 14;
- else PAD if the message has ended;
- else LOAD.
REQ-019 PAD SHALL write word wcnt as 0x80000000 if pad_done=0, otherwise 0x00000000, set pad_done, and increment wcnt.
REQ-020 LEN SHALL write len[63:32] to word 14 and len[31:0] to word 15, set len_done, and go to HASH.
REQ-021 HASH SHALL load the chaining register with the compression result and clear wcnt.
- Next state: DONE if len_done=1, PAD if the message has ended, else LOAD.
REQ-022 DONE SHALL:
- copy the chaining register to digest and pulse digest_valid for exactly this cycle;
- reload the chaining register with 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0;
- clear len, pad_done and len_done, and return to LOAD.
REQ-023 Latency: a final word accepted at wcnt=k (k<=12, pad placed) SHALL give digest_valid exactly 16-k cycles after acceptance.
REQ-024 digest SHALL hold its value between pulses.
REQ-025 len SHALL wrap modulo 2^64; messages SHALL be 1 byte to 2^61-1 bytes (an empty message is not supported).
REQ-026 in_nbytes=0 or >4 with in_last=1 SHALL be treated as 4.

Reset
REQ-027 On rst=1, asynchronously:
- state=LOAD; wcnt=0; len=0; pad_done=len_done=0;
- block register=0; chaining register=H init constants;
- digest=0; digest_valid=0; in_ready=1 once rst is released.
REQ-028 Reset mid-message SHALL discard all partial state; the next accepted word starts a new message.

Verification
REQ-029 The bench SHALL cover these scenarios:
- "abc": in_data=0x61626300, in_nbytes=3, in_last=1 -> digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d, digest_valid 16 cycles after acceptance.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (14 words, last in_nbytes=4) -> two blocks, digest 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
- Exactly 64-byte message (16 words, last in_nbytes=4) -> second block = 0x80000000, zeros, length 0x0000000000000200; digest matches a software model.
- Back-pressure: in_valid held high through PAD/LEN/HASH -> in_ready=0 and no word consumed; two back-to-back "abc" messages -> identical digests.
- Reset asserted after 5 words of a message, then "abc" -> digest a9993e36..., no stale chaining.
